mac_array_ctrl: RTL and testbench
=================================

Name: mac_array_ctrl

Overview:
Sequencer that drives one MacArray through a full tile: weight prefetch, row-skewed ifmap streaming and ofmap drain tracking. It reads weights and ifmap vectors from on-chip buffers with 1-cycle read latency and generates the MacArray control and data buses. It counts ofmap beats per column and reports completion to the top-level scheduler.

Parameters:
MAC_ROW, 16, array rows (ifmap lanes, weight rows)
MAC_COL, 16, array columns (weight lanes, ofmap lanes)
IFMAP_BITWIDTH, 16, ifmap element width
W_BITWIDTH, 8, weight element width
IFMAP_ADDR_W, 10, ifmap buffer address width; max N = 2^IFMAP_ADDR_W

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start_in  in  1  pulse; start tile; sampled only in IDLE
ifmap_num_in  in  IFMAP_ADDR_W+1  N, ifmap vectors per tile; latched on accepted start
busy_out  out  1  high from accepted start through DONE inclusive
done_out  out  1  1-cycle pulse at tile end
err_out  out  1  sticky; ofmap_valid_in beat on a column already at N; cleared by rst or accepted start
w_rd_en_out  out  1  weight buffer read enable
w_rd_addr_out  out  clog2(MAC_ROW)  weight row address
w_rd_data_in  in  MAC_COL*W_BITWIDTH  weight row, valid 1 cycle after read
if_rd_en_out  out  1  ifmap buffer read enable
if_rd_addr_out  out  IFMAP_ADDR_W  ifmap vector address
if_rd_data_in  in  MAC_ROW*IFMAP_BITWIDTH  ifmap vector, valid 1 cycle after read
w_prefetch_out  out  1  to MacArray
w_enable_out  out  1  to MacArray
w_data_out  out  MAC_COL*W_BITWIDTH  to MacArray
ifmap_start_out  out  1  to MacArray
ifmap_enable_out  out  MAC_ROW  to MacArray, per-row skewed
ifmap_data_out  out  MAC_ROW*IFMAP_BITWIDTH  to MacArray, per-row skewed
ofmap_valid_in  in  MAC_COL  from MacArray

Behaviour:
- Reset: every output 0, state IDLE, skew pipeline and column counters cleared. rst mid-tile aborts immediately; no done_out.
- FSM: IDLE -> PREFETCH -> WLOAD -> IFSTART -> FEED -> DRAIN -> DONE -> IDLE.
- Accepted start at edge T0. PREFETCH at T0+1: w_prefetch_out=1, read weight addr MAC_ROW-1.
- WLOAD, MAC_ROW cycles, k=0..MAC_ROW-1: w_enable_out=1, w_data_out=w_rd_data_in (row MAC_ROW-1-k). Issue read of row MAC_ROW-2-k while k<MAC_ROW-1. Weight rows go out in reverse order, last row first.
- IFSTART, 1 cycle: ifmap_start_out=1, read ifmap addr 0.
- FEED, N cycles, n=0..N-1: buffer data for vector n is present. Issue read of n+1 while n+1<N.
  - Lane r passes through r register stages, so row r sees vector n at FEED cycle n+r. Lane 0 is unregistered.
  - ifmap_enable_out[r] is the FEED-valid flag delayed identically.
- ifmap_data_out lane is 0 whenever its enable is 0. w_data_out is 0 when w_enable_out=0.
- DRAIN: skew pipeline empties; stay until every column count == N. A column count increments on ofmap_valid_in[c] and saturates at N. Counting is active in FEED and DRAIN.
- DONE, 1 cycle: done_out=1, then IDLE.
- Boundaries:
  - N==0: after WLOAD go directly to DONE, no ifmap_start_out; acts as weight-only reload.
  - start_in while busy: ignored.
  - start_in in the DONE cycle: ignored. It is accepted one cycle later in IDLE.
  - N = 2^IFMAP_ADDR_W: addresses cover 0..N-1 without wrap.
  - A beat on a column already at N sets err_out and the count does not change.
- No combinational path from start_in to any output.

Optional Feature:
MAC_CTRL_PERF_EN
- Defined: adds output perf_cycles_out, 32 bits, zero-based.
  - Counts cycles from PREFETCH through DRAIN inclusive.
  - Holds the value after done_out and clears on the next accepted start. Reset value 0.
  - Saturates at 2^32-1.
- Undefined: port absent, no counter logic.

Test Plan:
- Defaults, N=4, ramp data. Check:
  - w_prefetch_out at T0+1.
  - w_enable_out high for 16 cycles with weight rows 15..0.
  - ifmap_start_out at T0+18.
  - ifmap_enable_out[0] high T0+19..T0+22 and [15] high T0+34..T0+37.
  - With a MacArray model, done_out once after all 16 columns report 4 beats.
- N=0 -> 16 weight beats, no ifmap_start_out, done_out at T0+18, busy_out low at T0+19.
- start_in pulsed during FEED of an N=8 tile -> ignored. Exactly 8 reads at addrs 0..7 and one done_out.
- rst during FEED at n=3 -> next cycle all outputs 0, state IDLE, no done_out. A new N=2 tile then completes normally.
- Force an extra ofmap_valid_in[5] beat after its count reaches N -> err_out=1 and stays set. It clears on the next accepted start.
- MAC_CTRL_PERF_EN, N=4: perf_cycles_out equals the observed cycle count from PREFETCH to the last DRAIN cycle and holds after done_out. Build without the macro: the port is absent and the module compiles.

Source files
------------

// File: rtl/mac_array_ctrl_if.sv
// Bus bundle between mac_array_ctrl and its weight/ifmap buffers, the MacArray and the tile scheduler.
// perf_cycles_out is present only when MAC_CTRL_PERF_EN is defined.
interface mac_array_ctrl_if #(
    parameter int MAC_ROW        = 16,
    parameter int MAC_COL        = 16,
    parameter int IFMAP_BITWIDTH = 16,
    parameter int W_BITWIDTH     = 8,
    parameter int IFMAP_ADDR_W   = 10
);
    localparam int WA_W = (MAC_ROW > 1) ? $clog2(MAC_ROW) : 1;

    logic                               start_in;
    logic [IFMAP_ADDR_W:0]              ifmap_num_in;
    logic                               busy_out;
    logic                               done_out;
    logic                               err_out;
    logic                               w_rd_en_out;
    logic [WA_W-1:0]                    w_rd_addr_out;
    logic [MAC_COL*W_BITWIDTH-1:0]      w_rd_data_in;
    logic                               if_rd_en_out;
    logic [IFMAP_ADDR_W-1:0]            if_rd_addr_out;
    logic [MAC_ROW*IFMAP_BITWIDTH-1:0]  if_rd_data_in;
    logic                               w_prefetch_out;
    logic                               w_enable_out;
    logic [MAC_COL*W_BITWIDTH-1:0]      w_data_out;
    logic                               ifmap_start_out;
    logic [MAC_ROW-1:0]                 ifmap_enable_out;
    logic [MAC_ROW*IFMAP_BITWIDTH-1:0]  ifmap_data_out;
    logic [MAC_COL-1:0]                 ofmap_valid_in;
`ifdef MAC_CTRL_PERF_EN
    logic [31:0]                        perf_cycles_out;
`endif

    modport master (
        input  start_in, ifmap_num_in, w_rd_data_in, if_rd_data_in, ofmap_valid_in,
        output busy_out, done_out, err_out, w_rd_en_out, w_rd_addr_out,
               if_rd_en_out, if_rd_addr_out, w_prefetch_out, w_enable_out, w_data_out,
               ifmap_start_out, ifmap_enable_out, ifmap_data_out
`ifdef MAC_CTRL_PERF_EN
        , output perf_cycles_out
`endif
    );

    modport slave (
        output start_in, ifmap_num_in, w_rd_data_in, if_rd_data_in, ofmap_valid_in,
        input  busy_out, done_out, err_out, w_rd_en_out, w_rd_addr_out,
               if_rd_en_out, if_rd_addr_out, w_prefetch_out, w_enable_out, w_data_out,
               ifmap_start_out, ifmap_enable_out, ifmap_data_out
`ifdef MAC_CTRL_PERF_EN
        , input perf_cycles_out
`endif
    );
endinterface

// File: rtl/mac_array_ctrl.sv
// Tile sequencer for one MacArray: weight prefetch/load, row-skewed ifmap feed, ofmap drain tracking.
// Optional MAC_CTRL_PERF_EN adds a saturating busy-cycle counter on perf_cycles_out.
module mac_array_ctrl #(
    parameter int MAC_ROW        = 16,
    parameter int MAC_COL        = 16,
    parameter int IFMAP_BITWIDTH = 16,
    parameter int W_BITWIDTH     = 8,
    parameter int IFMAP_ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    mac_array_ctrl_if.master  bus
);
    localparam int WA_W  = (MAC_ROW > 1) ? $clog2(MAC_ROW) : 1;
    localparam int CNT_W = IFMAP_ADDR_W + 1;
    localparam int IW    = IFMAP_BITWIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_PREFETCH, S_WLOAD, S_IFSTART, S_FEED, S_DRAIN, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_q;
    logic [CNT_W-1:0]   step_q;
    logic [CNT_W-1:0]   col_cnt_q [MAC_COL];
    logic               err_q;
    logic [MAC_ROW-1:1] vld_q;
    logic [MAC_ROW-1:0] lane_en;
    logic [IW-1:0]      lane_data [MAC_ROW];
    logic               start_acc;
    logic               feed;
    logic               counting;
    logic               all_full;

    assign start_acc = (state_q == S_IDLE) && bus.start_in;
    assign feed      = (state_q == S_FEED);
    assign counting  = (state_q == S_FEED) || (state_q == S_DRAIN);
    assign lane_en   = {vld_q, feed};

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (bus.start_in) state_d = S_PREFETCH;
            S_PREFETCH: state_d = S_WLOAD;
            S_WLOAD:    if (step_q == CNT_W'(MAC_ROW - 1))
                            state_d = (num_q == '0) ? S_DONE : S_IFSTART;
            S_IFSTART:  state_d = S_FEED;
            S_FEED:     if (step_q == num_q - CNT_W'(1)) state_d = S_DRAIN;
            S_DRAIN:    if ((vld_q == '0) && all_full) state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy_out        = (state_q != S_IDLE);
        bus.done_out        = 1'b0;
        bus.w_prefetch_out  = 1'b0;
        bus.w_enable_out    = 1'b0;
        bus.w_data_out      = '0;
        bus.w_rd_en_out     = 1'b0;
        bus.w_rd_addr_out   = '0;
        bus.ifmap_start_out = 1'b0;
        bus.if_rd_en_out    = 1'b0;
        bus.if_rd_addr_out  = '0;
        case (state_q)
            S_PREFETCH: begin
                bus.w_prefetch_out = 1'b1;
                bus.w_rd_en_out    = 1'b1;
                bus.w_rd_addr_out  = WA_W'(MAC_ROW - 1);
            end
            S_WLOAD: begin
                // Rows are loaded last-first; each cycle presents the row read one cycle earlier.
                bus.w_enable_out = 1'b1;
                bus.w_data_out   = bus.w_rd_data_in;
                if (step_q < CNT_W'(MAC_ROW - 1)) begin
                    bus.w_rd_en_out   = 1'b1;
                    bus.w_rd_addr_out = WA_W'(MAC_ROW - 2) - step_q[WA_W-1:0];
                end
            end
            S_IFSTART: begin
                bus.ifmap_start_out = 1'b1;
                bus.if_rd_en_out    = 1'b1;
            end
            S_FEED: begin
                if (step_q + CNT_W'(1) < num_q) begin
                    bus.if_rd_en_out   = 1'b1;
                    bus.if_rd_addr_out = step_q[IFMAP_ADDR_W-1:0] + IFMAP_ADDR_W'(1);
                end
            end
            S_DONE:  bus.done_out = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q  <= '0;
            step_q <= '0;
        end else begin
            if (start_acc) num_q <= bus.ifmap_num_in;
            if (state_d != state_q)
                step_q <= '0;
            else if ((state_q == S_WLOAD) || (state_q == S_FEED))
                step_q <= step_q + CNT_W'(1);
        end
    end

    // Per-column ofmap beat counters; a beat beyond N flags an error and is dropped.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            err_q <= 1'b0;
            for (int c = 0; c < MAC_COL; c++) col_cnt_q[c] <= '0;
        end else if (counting) begin
            for (int c = 0; c < MAC_COL; c++) begin
                if (bus.ofmap_valid_in[c]) begin
                    if (col_cnt_q[c] == num_q) err_q <= 1'b1;
                    else                       col_cnt_q[c] <= col_cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        all_full = 1'b1;
        for (int c = 0; c < MAC_COL; c++)
            if (col_cnt_q[c] != num_q) all_full = 1'b0;
    end

    assign bus.err_out = err_q;

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= lane_en[MAC_ROW-2:0];
    end

    assign lane_data[0] = bus.if_rd_data_in[IW-1:0];

    for (genvar r = 1; r < MAC_ROW; r++) begin : g_skew
        logic [IW-1:0] sh_q [r];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < r; s++) sh_q[s] <= '0;
            end else begin
                sh_q[0] <= bus.if_rd_data_in[r*IW +: IW];
                for (int s = 1; s < r; s++) sh_q[s] <= sh_q[s-1];
            end
        end
        assign lane_data[r] = sh_q[r-1];
    end

    assign bus.ifmap_enable_out = lane_en;

    always_comb begin
        bus.ifmap_data_out = '0;
        for (int r = 0; r < MAC_ROW; r++)
            if (lane_en[r]) bus.ifmap_data_out[r*IW +: IW] = lane_data[r];
    end

`ifdef MAC_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst || start_acc)
            perf_q <= '0;
        else if ((state_q inside {S_PREFETCH, S_WLOAD, S_IFSTART, S_FEED, S_DRAIN}) && (perf_q != '1))
            perf_q <= perf_q + 32'd1;
    end

    assign bus.perf_cycles_out = perf_q;
`endif
endmodule

// File: tb/tb_mac_array_ctrl.sv
// Bench for mac_array_ctrl: directed tiles with randomized buffer contents and ofmap latency,
// each cycle compared against expectations derived from the tile timeline (cycle 1 = PREFETCH).
`timescale 1ns/1ps
module tb_mac_array_ctrl;
    localparam int R   = 16;
    localparam int C   = 16;
    localparam int IW  = 16;
    localparam int WW  = 8;
    localparam int AW  = 10;
    localparam int IFS = R + 2;
    localparam int F0  = R + 3;
    typedef logic [255:0] v_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_array_ctrl_if #(.MAC_ROW(R), .MAC_COL(C), .IFMAP_BITWIDTH(IW), .W_BITWIDTH(WW),
                        .IFMAP_ADDR_W(AW)) bus ();

    mac_array_ctrl #(.MAC_ROW(R), .MAC_COL(C), .IFMAP_BITWIDTH(IW), .W_BITWIDTH(WW),
                     .IFMAP_ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [C*WW-1:0] wmem [R];
    logic [R*IW-1:0] imem [1 << AW];
    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    logic          w_req = 1'b0;
    logic          i_req = 1'b0;
    logic [3:0]    w_req_addr = '0;
    logic [AW-1:0] i_req_addr = '0;
    logic          err_exp = 1'b0;
    logic [31:0]   perf_prev = '0;

    task automatic chk(input string tag, input int c, input v_t obs, input v_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic drive_buf();
        v_t junk;
        for (int i = 0; i < 8; i++) junk[i*32 +: 32] = $urandom;
        bus.w_rd_data_in  = w_req ? wmem[w_req_addr] : junk[C*WW-1:0];
        bus.if_rd_data_in = i_req ? imem[i_req_addr] : junk;
    endtask

    task automatic capture();
        w_req      = bus.w_rd_en_out;
        w_req_addr = bus.w_rd_addr_out;
        i_req      = bus.if_rd_en_out;
        i_req_addr = bus.if_rd_addr_out;
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < R; i++)
            for (int k = 0; k < 4; k++) wmem[i][k*32 +: 32] = $urandom;
        for (int i = 0; i < (1 << AW); i++)
            for (int k = 0; k < 8; k++) imem[i][k*32 +: 32] = $urandom;
    endtask

    task automatic check_cycle(input int c, input int n, input int done_c, input bit dead);
        bit live;
        v_t ed;
        logic [R-1:0] een;
        live = !dead && (c >= 1);
        chk("busy", c, v_t'(bus.busy_out), v_t'(live && c <= done_c));
        chk("done", c, v_t'(bus.done_out), v_t'(live && c == done_c));
        chk("w_prefetch", c, v_t'(bus.w_prefetch_out), v_t'(live && c == 1));
        chk("w_enable", c, v_t'(bus.w_enable_out), v_t'(live && c >= 2 && c <= R + 1));
        chk("w_data", c, v_t'(bus.w_data_out),
            (live && c >= 2 && c <= R + 1) ? v_t'(wmem[R + 1 - c]) : v_t'(0));
        chk("w_rd_en", c, v_t'(bus.w_rd_en_out), v_t'(live && c <= R));
        if (live && c <= R) chk("w_rd_addr", c, v_t'(bus.w_rd_addr_out), v_t'(R - c));
        chk("ifmap_start", c, v_t'(bus.ifmap_start_out), v_t'(live && n > 0 && c == IFS));
        chk("if_rd_en", c, v_t'(bus.if_rd_en_out), v_t'(live && c >= IFS && c < IFS + n));
        if (live && c >= IFS && c < IFS + n)
            chk("if_rd_addr", c, v_t'(bus.if_rd_addr_out), v_t'(c - IFS));
        een = '0;
        ed  = '0;
        for (int r = 0; r < R; r++) begin
            if (live && c >= F0 + r && c < F0 + r + n) begin
                een[r] = 1'b1;
                ed[r*IW +: IW] = imem[c - F0 - r][r*IW +: IW];
            end
        end
        chk("ifmap_enable", c, v_t'(bus.ifmap_enable_out), v_t'(een));
        chk("ifmap_data", c, v_t'(bus.ifmap_data_out), ed);
        chk("err", c, v_t'(bus.err_out), v_t'(err_exp));
`ifdef MAC_CTRL_PERF_EN
        chk("perf", c, v_t'(bus.perf_cycles_out),
            dead ? v_t'(0) : (c == 0 ? v_t'(perf_prev) : v_t'((c < done_c ? c : done_c) - 1)));
`endif
    endtask

    // MacArray stand-in: column col reports vector k at cycle base+k+col.
    task automatic run_tile(input int n, input int lat, input int pulse_c, input int abort_c,
                            input int extra_c, input bit hold_start);
        int base, done_c, last_c;
        logic [C-1:0] ov;
        base   = F0 + R - 1 + lat;
        done_c = (n == 0) ? IFS : base + n + C;
        last_c = (abort_c >= 0) ? abort_c + 2 : done_c;
        bus.ifmap_num_in = (AW + 1)'(n);
        for (int c = 0; c <= last_c; c++) begin
            bit dead;
            dead = (abort_c >= 0) && (c > abort_c);
            drive_buf();
            bus.start_in = (c == 0) || (c == pulse_c) || (hold_start && c == done_c);
            rst = (c == abort_c);
            ov = '0;
            if (!dead)
                for (int col = 0; col < C; col++)
                    if (c - base - col >= 0 && c - base - col < n) ov[col] = 1'b1;
            if (c == extra_c) ov[5] = 1'b1;
            bus.ofmap_valid_in = ov;
            #4;
            check_cycle(c, n, done_c, dead);
            if (c == 0 || c == abort_c) err_exp = 1'b0;
            if (c == extra_c) err_exp = 1'b1;
            capture();
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        bus.start_in = 1'b0;
        perf_prev = (abort_c >= 0) ? 32'd0 : 32'(done_c - 1);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            drive_buf();
            bus.start_in = 1'b0;
            rst = 1'b0;
            bus.ofmap_valid_in = C'($urandom);
            #4;
            check_cycle(0, 0, -1, 1'b0);
            capture();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n, lat;
        for (int i = 0; i < R; i++)
            for (int col = 0; col < C; col++) wmem[i][col*WW +: WW] = WW'(i * 16 + col);
        for (int i = 0; i < (1 << AW); i++)
            for (int r = 0; r < R; r++) imem[i][r*IW +: IW] = IW'(i * R + r);

        rst = 1'b1;
        bus.start_in = 1'b1;
        bus.ifmap_num_in = '0;
        bus.ofmap_valid_in = '1;
        drive_buf();
        repeat (2) @(posedge clk);
        #5;
        check_cycle(0, 0, -1, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.start_in = 1'b0;
        idle(2);

        run_tile(4, 1, -1, -1, -1, 1'b0);
        idle(2);
        run_tile(0, 1, -1, -1, -1, 1'b0);
        idle(2);
        run_tile(8, 2, F0 + 2, -1, -1, 1'b0);
        idle(1);
        run_tile(8, 1, -1, F0 + 3, -1, 1'b0);
        run_tile(2, 1, -1, -1, -1, 1'b0);
        idle(1);

        randomize_mem();
        run_tile(6, 1, -1, -1, (F0 + R) + 6 - 1 + 5 + 2, 1'b0);
        idle(3);
        run_tile(3, 2, -1, -1, -1, 1'b1);
        run_tile(5, 3, -1, -1, -1, 1'b0);
        idle(1);

        for (int t = 0; t < 4; t++) begin
            randomize_mem();
            n   = $urandom_range(1, 24);
            lat = $urandom_range(1, 4);
            run_tile(n, lat, -1, -1, -1, 1'b0);
            idle(1);
        end

        run_tile(1 << AW, 1, -1, -1, -1, 1'b0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
